out_port_uart_tx: RTL

Byte-wide output port for the custom 8-bit computer. The CPU's OUT instruction writes a byte with a one-cycle strobe. The block buffers the byte in a small FIFO and serializes it as an 8N1 UART frame (optionally 8E1) on a single `tx` pin. This is the transmit end of the host link; the bench-side receiver decodes this line. It sits between the CPU output-register decode and the FPGA pin.

---
 rtl/out_port_uart_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - CPU OUT port: byte FIFO feeding a UART transmitter, 8N1 by default.
// Define OUT_UART_PARITY_EN to add an even-parity bit (8E1 frames).
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        overflow,
    output logic                        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef OUT_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      head;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   baud_cnt;
    logic            baud_wrap;
    logic            push;
    logic            pop;
`ifdef OUT_UART_PARITY_EN
    logic            parity_bit;
`endif

    // full comes straight from the registered count, so a write while full is
    // dropped even when the FSM pops in the same cycle.
    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign push      = wr_en && !full;
    assign head      = mem[rd_ptr];
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign pop       = (fifo_count != '0) &&
                       ((state == IDLE) || ((state == STOP) && baud_wrap));

    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)
                overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            baud_cnt   <= '0;
`ifdef OUT_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (state == IDLE || baud_wrap)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shreg <= head;
`ifdef OUT_UART_PARITY_EN
                        parity_bit <= ^head;
`endif
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef OUT_UART_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        // Queued byte starts immediately so frames run back-to-back.
                        if (pop) begin
                            shreg <= head;
`ifdef OUT_UART_PARITY_EN
                            parity_bit <= ^head;
`endif
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
